// File: rtl/jk_reg_controller.sv
// Purpose : command-driven controller for a bank of WIDTH JK flip-flops; each
//           command applies one JK operation to the masked bits for CMD_CNT edges.
// Latency : accept at edge N, Q updates at N+1..N+cnt, DONE high after N+cnt,
//           CMD_READY returns one cycle after DONE.
// Backpressure: CMD_READY is low outside IDLE and while CLR is low; a command
//           is taken only on an edge where CMD_VALID and CMD_READY are both high.
//
// Ports:
//   CLK        clock, all state changes on the rising edge
//   CLR        asynchronous active-low reset
//   CMD_VALID  command present on CMD_OP / CMD_MASK / CMD_CNT
//   CMD_READY  controller can accept a command this cycle
//   CMD_OP     00 HOLD, 01 RESET, 10 SET, 11 TOGGLE (bit1 = J, bit0 = K)
//   CMD_MASK   bits the command applies to; unmasked bits see J=0, K=0
//   CMD_CNT    number of edges the command is applied (0 behaves as 1)
//   ABORT      cancels the executing command without a DONE pulse
//   Q / P      register bank state and its complement
//   BUSY       high while a command is executing or completing
//   DONE       one-cycle pulse on normal completion
//   OP_COUNT   modulo-256 count of normally completed commands
module jk_reg_controller #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [WIDTH-1:0] CMD_MASK,
  input  logic [CNT_W-1:0] CMD_CNT,
  input  logic             ABORT,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] P,
  output logic             BUSY,
  output logic             DONE,
  output logic [7:0]       OP_COUNT
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       op_lat;
  logic [WIDTH-1:0] mask_lat;
  logic [CNT_W-1:0] remaining;

  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;
  logic [WIDTH-1:0] q_next;

  // Ready is gated by CLR directly so it drops the instant reset asserts,
  // and rises again as soon as reset is released (state is already IDLE).
  assign CMD_READY = (state == S_IDLE) && CLR;

  // P is a pure inversion of the state register, so it can never disagree
  // with Q, not even during reset.
  assign P = ~Q;

  // Per-bit J/K derived from the latched op; the mask forces J=K=0 on
  // unselected bits. Standard JK characteristic: Q+ = J&~Q | ~K&Q.
  always_comb begin
    j_vec  = mask_lat & {WIDTH{op_lat[1]}};
    k_vec  = mask_lat & {WIDTH{op_lat[0]}};
    q_next = (j_vec & ~Q) | (~k_vec & Q);
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state     <= S_IDLE;
      op_lat    <= '0;
      mask_lat  <= '0;
      remaining <= '0;
      Q         <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      OP_COUNT  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // ABORT has no meaning here; a valid command is always taken.
          if (CMD_VALID) begin
            op_lat    <= CMD_OP;
            mask_lat  <= CMD_MASK;
            remaining <= (CMD_CNT == '0) ? CNT_W'(1) : CMD_CNT;
            state     <= S_EXEC;
            BUSY      <= 1'b1;
          end
        end

        S_EXEC: begin
          if (ABORT) begin
            // Cancel before applying this edge's repetition.
            remaining <= '0;
            state     <= S_IDLE;
            BUSY      <= 1'b0;
          end else begin
            Q         <= q_next;
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state <= S_DONE;
              DONE  <= 1'b1;
            end
          end
        end

        S_DONE: begin
          OP_COUNT <= OP_COUNT + 8'd1;
          DONE     <= 1'b0;
          BUSY     <= 1'b0;
          state    <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_reg_controller.sv
// Bench for jk_reg_controller: scenario tasks drive commands and check the
// per-edge behaviour inline; a negedge monitor pops the expected completion
// state from a queue on every DONE pulse and checks P against Q every cycle.
module tb_jk_reg_controller;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_RESET  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  logic             CLK = 1'b0;
  logic             CLR = 1'b1;
  logic             CMD_VALID = 1'b0;
  logic             CMD_READY;
  logic [1:0]       CMD_OP = 2'b00;
  logic [WIDTH-1:0] CMD_MASK = '0;
  logic [CNT_W-1:0] CMD_CNT = '0;
  logic             ABORT = 1'b0;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] P;
  logic             BUSY;
  logic             DONE;
  logic [7:0]       OP_COUNT;

  jk_reg_controller #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .CLR(CLR), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_MASK(CMD_MASK), .CMD_CNT(CMD_CNT), .ABORT(ABORT),
    .Q(Q), .P(P), .BUSY(BUSY), .DONE(DONE), .OP_COUNT(OP_COUNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] opc;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] model_q   = 8'h00;
  logic [7:0] model_opc = 8'h00;
  logic       opc_pending = 1'b0;
  logic [7:0] opc_exp = 8'h00;

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    checks++;
    if (P !== ~Q) $display("FAIL p_complement: P=%h required %h", P, ~Q);
    else passed++;
    if (opc_pending) begin
      opc_pending = 1'b0;
      checks++;
      if (OP_COUNT !== opc_exp) $display("FAIL sb_op_count: OP_COUNT=%h required %h", OP_COUNT, opc_exp);
      else passed++;
    end
    if (DONE === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_done: DONE=1 required 0 (no command pending completion)");
      end else begin
        mon_e = sb.pop_front();
        if (Q !== mon_e.q) $display("FAIL sb_q_at_done: Q=%h required %h", Q, mon_e.q);
        else passed++;
        opc_pending = 1'b1;
        opc_exp     = mon_e.opc;
      end
    end
  end

  // Waits for CMD_READY (bounded), presents one command for one edge, then
  // scrambles the command inputs. Returns 1 ns after the accepting edge.
  task automatic send_cmd(input logic [1:0] op, input logic [7:0] mask,
                          input logic [3:0] cnt, input bit completes);
    int         n;
    logic [7:0] r;
    logic [7:0] tgt;
    exp_t       e;
    for (int i = 0; i < 50 && CMD_READY !== 1'b1; i++) begin
      @(posedge CLK); #1;
    end
    if (CMD_READY !== 1'b1) begin
      checks++;
      $display("FAIL ready_timeout: CMD_READY=%b required 1", CMD_READY);
    end
    CMD_VALID = 1'b1;
    CMD_OP    = op;
    CMD_MASK  = mask;
    CMD_CNT   = cnt;
    if (completes) begin
      n = (cnt == 4'd0) ? 1 : int'(cnt);
      r = model_q;
      for (int i = 0; i < n; i++) begin
        case (op)
          OP_SET:    tgt = 8'hFF;
          OP_RESET:  tgt = 8'h00;
          OP_TOGGLE: tgt = ~r;
          default:   tgt = r;
        endcase
        r = (r & ~mask) | (tgt & mask);
      end
      model_q   = r;
      model_opc = model_opc + 8'd1;
      e.q   = r;
      e.opc = model_opc;
      sb.push_back(e);
    end
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    CMD_OP    = 2'($urandom);
    CMD_MASK  = 8'($urandom);
    CMD_CNT   = 4'($urandom);
  endtask

  task automatic test_reset();
    #1 CLR = 1'b0;
    #3;
    checks++; if (Q !== 8'h00) $display("FAIL rst_q: Q=%h required 00", Q); else passed++;
    checks++; if (P !== 8'hFF) $display("FAIL rst_p: P=%h required ff", P); else passed++;
    checks++; if (OP_COUNT !== 8'h00) $display("FAIL rst_opc: OP_COUNT=%h required 00", OP_COUNT); else passed++;
    checks++; if (DONE !== 1'b0) $display("FAIL rst_done: DONE=%b required 0", DONE); else passed++;
    checks++; if (BUSY !== 1'b0) $display("FAIL rst_busy: BUSY=%b required 0", BUSY); else passed++;
    checks++; if (CMD_READY !== 1'b0) $display("FAIL rst_ready: CMD_READY=%b required 0", CMD_READY); else passed++;
    @(negedge CLK);
    CLR       = 1'b1;
    model_q   = 8'h00;
    model_opc = 8'h00;
    #1;
    checks++; if (CMD_READY !== 1'b1) $display("FAIL rst_release_ready: CMD_READY=%b required 1", CMD_READY); else passed++;
  endtask

  task automatic test_set();
    send_cmd(OP_SET, 8'hFF, 4'd1, 1'b1);
    checks++; if (Q !== 8'h00) $display("FAIL set_accept_q: Q=%h required 00", Q); else passed++;
    checks++; if (BUSY !== 1'b1) $display("FAIL set_busy: BUSY=%b required 1", BUSY); else passed++;
    checks++; if (CMD_READY !== 1'b0) $display("FAIL set_ready_low: CMD_READY=%b required 0", CMD_READY); else passed++;
    @(posedge CLK); #1;
    checks++; if (Q !== 8'hFF) $display("FAIL set_q: Q=%h required ff", Q); else passed++;
    checks++; if (DONE !== 1'b1) $display("FAIL set_done: DONE=%b required 1", DONE); else passed++;
    @(posedge CLK); #1;
    checks++; if (DONE !== 1'b0) $display("FAIL set_done_width: DONE=%b required 0", DONE); else passed++;
    checks++; if (BUSY !== 1'b0) $display("FAIL set_busy_end: BUSY=%b required 0", BUSY); else passed++;
    checks++; if (CMD_READY !== 1'b1) $display("FAIL set_ready_back: CMD_READY=%b required 1", CMD_READY); else passed++;
    checks++; if (OP_COUNT !== 8'd1) $display("FAIL set_opc: OP_COUNT=%h required 01", OP_COUNT); else passed++;
  endtask

  task automatic test_cnt_zero();
    send_cmd(OP_RESET, 8'h0F, 4'd0, 1'b1);
    @(posedge CLK); #1;
    checks++; if (Q !== 8'hF0) $display("FAIL cnt0_q: Q=%h required f0", Q); else passed++;
    checks++; if (DONE !== 1'b1) $display("FAIL cnt0_done: DONE=%b required 1", DONE); else passed++;
    @(posedge CLK); #1;
    checks++; if (OP_COUNT !== 8'd2) $display("FAIL cnt0_opc: OP_COUNT=%h required 02", OP_COUNT); else passed++;
  endtask

  task automatic test_toggle();
    logic [7:0] seq3 [3];
    logic       dn3  [3];
    seq3 = '{8'h0F, 8'hF0, 8'h0F};
    dn3  = '{1'b0, 1'b0, 1'b1};
    send_cmd(OP_TOGGLE, 8'hFF, 4'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      checks++; if (Q !== seq3[i]) $display("FAIL tog3_q%0d: Q=%h required %h", i, Q, seq3[i]); else passed++;
      checks++; if (DONE !== dn3[i]) $display("FAIL tog3_done%0d: DONE=%b required %b", i, DONE, dn3[i]); else passed++;
    end
    send_cmd(OP_TOGGLE, 8'hFF, 4'd2, 1'b1);
    @(posedge CLK); #1;
    checks++; if (Q !== 8'hF0) $display("FAIL tog2_mid: Q=%h required f0", Q); else passed++;
    @(posedge CLK); #1;
    checks++; if (Q !== 8'h0F) $display("FAIL tog2_q: Q=%h required 0f", Q); else passed++;
    checks++; if (DONE !== 1'b1) $display("FAIL tog2_done: DONE=%b required 1", DONE); else passed++;
    @(posedge CLK); #1;
    checks++; if (OP_COUNT !== 8'd4) $display("FAIL tog2_opc: OP_COUNT=%h required 04", OP_COUNT); else passed++;
  endtask

  task automatic test_abort();
    send_cmd(OP_TOGGLE, 8'hFF, 4'd5, 1'b0);
    @(posedge CLK); #1;
    model_q = model_q ^ 8'hFF;
    checks++; if (Q !== model_q) $display("FAIL abort_first_toggle: Q=%h required %h", Q, model_q); else passed++;
    ABORT = 1'b1;
    @(posedge CLK); #1;
    ABORT = 1'b0;
    checks++; if (Q !== model_q) $display("FAIL abort_no_update: Q=%h required %h", Q, model_q); else passed++;
    checks++; if (BUSY !== 1'b0) $display("FAIL abort_busy: BUSY=%b required 0", BUSY); else passed++;
    checks++; if (DONE !== 1'b0) $display("FAIL abort_done: DONE=%b required 0", DONE); else passed++;
    checks++; if (CMD_READY !== 1'b1) $display("FAIL abort_ready: CMD_READY=%b required 1", CMD_READY); else passed++;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (OP_COUNT !== model_opc) $display("FAIL abort_opc: OP_COUNT=%h required %h", OP_COUNT, model_opc); else passed++;
    checks++; if (Q !== model_q) $display("FAIL abort_q_stable: Q=%h required %h", Q, model_q); else passed++;
  endtask

  task automatic test_abort_in_idle();
    ABORT = 1'b1;
    send_cmd(OP_SET, 8'h01, 4'd1, 1'b1);
    ABORT = 1'b0;
    checks++; if (BUSY !== 1'b1) $display("FAIL idle_abort_accept: BUSY=%b required 1", BUSY); else passed++;
    @(posedge CLK); #1;
    checks++; if (Q !== model_q) $display("FAIL idle_abort_q: Q=%h required %h", Q, model_q); else passed++;
    checks++; if (DONE !== 1'b1) $display("FAIL idle_abort_done: DONE=%b required 1", DONE); else passed++;
    @(posedge CLK); #1;
  endtask

  task automatic test_mask_zero();
    logic [7:0] q0;
    q0 = model_q;
    send_cmd(OP_SET, 8'h00, 4'd2, 1'b1);
    @(posedge CLK); #1;
    checks++; if (Q !== q0) $display("FAIL mask0_q1: Q=%h required %h", Q, q0); else passed++;
    checks++; if (DONE !== 1'b0) $display("FAIL mask0_early_done: DONE=%b required 0", DONE); else passed++;
    @(posedge CLK); #1;
    checks++; if (Q !== q0) $display("FAIL mask0_q2: Q=%h required %h", Q, q0); else passed++;
    checks++; if (DONE !== 1'b1) $display("FAIL mask0_done: DONE=%b required 1", DONE); else passed++;
    @(posedge CLK); #1;
    checks++; if (OP_COUNT !== model_opc) $display("FAIL mask0_opc: OP_COUNT=%h required %h", OP_COUNT, model_opc); else passed++;
  endtask

  task automatic test_clr_mid_exec();
    send_cmd(OP_TOGGLE, 8'hFF, 4'd4, 1'b0);
    @(posedge CLK); #1;
    checks++; if (Q !== (model_q ^ 8'hFF)) $display("FAIL clr_pre_q: Q=%h required %h", Q, model_q ^ 8'hFF); else passed++;
    #2 CLR = 1'b0;
    #1;
    checks++; if (Q !== 8'h00) $display("FAIL clr_q: Q=%h required 00", Q); else passed++;
    checks++; if (P !== 8'hFF) $display("FAIL clr_p: P=%h required ff", P); else passed++;
    checks++; if (OP_COUNT !== 8'h00) $display("FAIL clr_opc: OP_COUNT=%h required 00", OP_COUNT); else passed++;
    checks++; if (BUSY !== 1'b0) $display("FAIL clr_busy: BUSY=%b required 0", BUSY); else passed++;
    @(negedge CLK);
    CLR       = 1'b1;
    model_q   = 8'h00;
    model_opc = 8'h00;
    repeat (6) @(posedge CLK);
    #1;
    checks++; if (OP_COUNT !== 8'h00) $display("FAIL clr_opc_after: OP_COUNT=%h required 00", OP_COUNT); else passed++;
    checks++; if (Q !== 8'h00) $display("FAIL clr_q_after: Q=%h required 00", Q); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] start_opc;
    send_cmd(OP_SET, 8'hA5, 4'd1, 1'b1);
    start_opc = model_opc;
    for (int i = 0; i < 256; i++) send_cmd(OP_HOLD, 8'($urandom), 4'd1, 1'b1);
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (OP_COUNT !== start_opc) $display("FAIL b2b_wrap: OP_COUNT=%h required %h", OP_COUNT, start_opc); else passed++;
    checks++; if (Q !== 8'hA5) $display("FAIL b2b_q: Q=%h required a5", Q); else passed++;
  endtask

  initial begin
    test_reset();
    test_set();
    test_cnt_zero();
    test_toggle();
    test_abort();
    test_abort_in_idle();
    test_mask_zero();
    test_clr_mid_exec();
    test_back_to_back();
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (sb.size() != 0) $display("FAIL sb_drained: pending=%0d required 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
